// File: rtl/seq_restoring_divider4.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// Produces one quotient bit per clock; a zero divisor finishes after one cycle.
module seq_restoring_divider4 #(
  parameter int WIDTH = 4,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Trial subtraction as a (WIDTH+1)-bit add of the inverted divisor plus one;
  // the top bit of the result is set exactly when the subtraction borrows.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   minuend,
                                               input logic [WIDTH-1:0] subtrahend);
    trial_sub = minuend + {1'b1, ~subtrahend} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] qsr_nx_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qsr_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qsr_q   <= qsr_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept, iterate, publish.
  always_comb begin
    state_d  = state_q;
    qsr_d    = qsr_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    quo_d    = quo_q;
    res_d    = res_q;
    dbz_d    = dbz_q;

    // Remainder stays below the divisor, so it fits WIDTH bits before the shift.
    rem_sh_s = {rem_q, qsr_q[WIDTH-1]};
    trial_s  = trial_sub(rem_sh_s, div_q);
    if (trial_s[WIDTH] == 1'b0) begin
      rem_nx_s = trial_s[WIDTH-1:0];
      qsr_nx_s = {qsr_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[WIDTH-1:0];
      qsr_nx_s = {qsr_q[WIDTH-2:0], 1'b0};
    end

    case (state_q)
      S_IDLE, S_FIN: begin
        done_d = 1'b0;
        if (start) begin
          qsr_d   = A;
          div_d   = B;
          rem_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (div_q == {WIDTH{1'b0}}) begin
          quo_d   = {WIDTH{1'b1}};
          res_d   = qsr_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          qsr_d = qsr_nx_s;
          rem_d = rem_nx_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(ITER - 1)) begin
            quo_d   = qsr_nx_s;
            res_d   = rem_nx_s;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = quo_q;
  assign R           = res_q;
  assign div_by_zero = dbz_q;

endmodule
